// File: rtl/st_mx_pkg.sv
// ----------------------------------------------------------------------------
// st_mx_pkg
// Shared types and defaults for the MX receive-side datapath.
//   prec_mode_t  : per-beat precision mode carried alongside level-1 sums
//   norm_state_t : control states of the normalizing accumulator
//   EXP_BASE_DEF : exponent bias removed before FP8 alignment
//   MAX_SH_DEF   : largest FP8 alignment shift
//   acc_width()  : accumulator width that cannot wrap within a full block
// ----------------------------------------------------------------------------
package st_mx_pkg;

  typedef enum logic [1:0] {
    INT8  = 2'b00,
    FP8_A = 2'b01,
    FP8_B = 2'b10,
    FP4   = 2'b11
  } prec_mode_t;

  typedef enum logic [1:0] {
    S_ACC,
    S_ABS,
    S_NORM,
    S_OUT
  } norm_state_t;

  localparam int EXP_BASE_DEF = 2;
  localparam int MAX_SH_DEF   = 12;

  // Sign bit plus the widest aligned term plus growth for summing a full block.
  function automatic int acc_width(input int mant_in_w, input int max_sh,
                                   input int max_beats);
    return mant_in_w + max_sh + $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/st_lzc.sv
// ----------------------------------------------------------------------------
// st_lzc
// Combinational leading-zero counter.
//   value    in  W   word to scan
//   count    out CW  number of zeros above the most significant one (W if zero)
//   all_zero out 1   value is exactly zero
// ----------------------------------------------------------------------------
module st_lzc #(
  parameter int W  = 26,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) begin
        count = CW'(W - 1 - i);
      end
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/st_norm_acc_lvl1.sv
// ----------------------------------------------------------------------------
// st_norm_acc_lvl1
// Accumulates a block of unnormalized level-1 sums into a signed fixed-point
// accumulator and, at block end, returns sign / leading-one index / truncated
// mantissa of the total.
//   clk, rst       clock and synchronous active-high reset
//   in_valid/ready beat handshake (ready only while accumulating)
//   in_mant/exp/sign/last, prec_mode   level-1 beat and its precision mode
//   out_valid/ready result handshake
//   out_sign/exp/mant/zero/overrun     registered normalized result
// ----------------------------------------------------------------------------
module st_norm_acc_lvl1
  import st_mx_pkg::*;
#(
  parameter int MANT_W    = 8,
  parameter int MAX_BEATS = 8,
  parameter int EXP_BASE  = EXP_BASE_DEF,
  parameter int MAX_SH    = MAX_SH_DEF,
  parameter int ACC_W     = acc_width(10, MAX_SH, MAX_BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        in_mant,
  input  logic [5:0]        in_exp,
  input  logic              in_sign,
  input  logic              in_last,
  input  logic [1:0]        prec_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [4:0]        out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_overrun
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int LZC_W = $clog2(ACC_W) + 1;

  norm_state_t       state;
  prec_mode_t        mode;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  mag;
  logic [ACC_W-1:0]  term;
  logic [ACC_W-1:0]  abs_q;
  logic [ACC_W-1:0]  norm_shift;
  logic [MANT_W-1:0] norm_mant;
  logic [4:0]        norm_exp;
  logic [CNT_W-1:0]  beat_cnt;
  logic [5:0]        sh;
  logic              accept;
  logic              last_slot;
  logic              close_blk;
  logic              overrun_q;
  logic              sign_q;
  logic              zero_q;
  logic              norm_phase;
  logic [LZC_W-1:0]  lzc_cnt;
  logic [LZC_W-1:0]  lzc_q;
  logic              lzc_zero;

  // Beats are only taken while accumulating; reset masks ready so that beats
  // presented during reset are never counted as accepted.
  assign in_ready  = (state == S_ACC) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_slot = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign close_blk = in_last || last_slot;
  assign mode      = prec_mode_t'(prec_mode);

  // FP8 alignment: remove the exponent bias, clamp below at zero and above
  // at the largest shift the accumulator was sized for.
  always_comb begin
    sh = '0;
    if (in_exp > 6'(EXP_BASE)) begin
      if ((in_exp - 6'(EXP_BASE)) > 6'(MAX_SH)) begin
        sh = 6'(MAX_SH);
      end else begin
        sh = in_exp - 6'(EXP_BASE);
      end
    end
  end

  // Build the signed term for this beat. FP4 sums already arrive in two's
  // complement (sign is the top bit), the other modes are sign-magnitude.
  always_comb begin
    mag  = '0;
    term = '0;
    case (mode)
      FP4: begin
        term = {{(ACC_W-11){in_sign}}, in_sign, in_mant};
      end
      INT8: begin
        mag  = {{(ACC_W-10){1'b0}}, in_mant};
        term = in_sign ? -mag : mag;
      end
      default: begin
        mag  = {{(ACC_W-10){1'b0}}, in_mant} << sh;
        term = in_sign ? -mag : mag;
      end
    endcase
  end

  st_lzc #(
    .W  (ACC_W),
    .CW (LZC_W)
  ) u_lzc (
    .value    (abs_q),
    .count    (lzc_cnt),
    .all_zero (lzc_zero)
  );

  // Left-justify the magnitude at its leading one; the top MANT_W bits are
  // the mantissa and everything below is truncated.
  assign norm_shift = abs_q << lzc_q;
  assign norm_mant  = MANT_W'(norm_shift >> (ACC_W - MANT_W));
  assign norm_exp   = 5'(ACC_W - 1 - int'(lzc_q));

  // Block controller and datapath registers. Normalization is split over two
  // edges (count leading zeros, then shift) so the scan and the barrel shift
  // never sit in one path; that gives three edges from closing beat to
  // out_valid. The accumulator and counter are cleared when the result is
  // taken, so each block starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ACC;
      acc         <= '0;
      beat_cnt    <= '0;
      overrun_q   <= 1'b0;
      sign_q      <= 1'b0;
      abs_q       <= '0;
      lzc_q       <= '0;
      zero_q      <= 1'b0;
      norm_phase  <= 1'b0;
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_zero    <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (accept) begin
            acc <= acc + term;
            if (close_blk) begin
              overrun_q <= ~in_last;
              state     <= S_ABS;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_ABS: begin
          // The most negative value negates to itself, which read unsigned
          // is exactly its magnitude.
          sign_q     <= acc[ACC_W-1];
          abs_q      <= acc[ACC_W-1] ? -acc : acc;
          norm_phase <= 1'b0;
          state      <= S_NORM;
        end
        S_NORM: begin
          if (!norm_phase) begin
            lzc_q      <= lzc_cnt;
            zero_q     <= lzc_zero;
            norm_phase <= 1'b1;
          end else begin
            out_sign    <= zero_q ? 1'b0 : sign_q;
            out_exp     <= zero_q ? 5'd0 : norm_exp;
            out_mant    <= zero_q ? '0 : norm_mant;
            out_zero    <= zero_q;
            out_overrun <= overrun_q;
            out_valid   <= 1'b1;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
            state     <= S_ACC;
          end
        end
        default: begin
          state <= S_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_norm_acc_lvl1.sv
// ----------------------------------------------------------------------------
// tb_st_norm_acc_lvl1
// Directed bench for st_norm_acc_lvl1 with an arithmetic reference model and a
// per-cycle compare process, plus literal expectations for each directed block.
// ----------------------------------------------------------------------------
module tb_st_norm_acc_lvl1;

  localparam int MANT_W    = 8;
  localparam int MAX_BEATS = 8;
  localparam int EXP_BASE  = 2;
  localparam int MAX_SH    = 12;
  localparam int ACC_W     = 26;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [9:0]        in_mant = '0;
  logic [5:0]        in_exp = '0;
  logic              in_sign = 1'b0;
  logic              in_last = 1'b0;
  logic [1:0]        prec_mode = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_sign;
  logic [4:0]        out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_zero;
  logic              out_overrun;

  int checks = 0;
  int errors = 0;

  st_norm_acc_lvl1 #(
    .MANT_W    (MANT_W),
    .MAX_BEATS (MAX_BEATS),
    .EXP_BASE  (EXP_BASE),
    .MAX_SH    (MAX_SH),
    .ACC_W     (ACC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mant     (in_mant),
    .in_exp      (in_exp),
    .in_sign     (in_sign),
    .in_last     (in_last),
    .prec_mode   (prec_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_exp     (out_exp),
    .out_mant    (out_mant),
    .out_zero    (out_zero),
    .out_overrun (out_overrun)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_busy = 0;
  bit     m_vld = 0;
  bit     m_rst = 0;
  int     m_cd = 0;
  bit     r_sign = 0;
  int     r_exp = 0;
  int     r_mant = 0;
  bit     r_zero = 0;
  bit     r_ovr = 0;

  function automatic longint model_term(input logic [1:0] mode, input logic [9:0] mant,
                                        input logic [5:0] e, input logic sgn);
    longint v;
    int s;
    if (mode == 2'b11) begin
      v = longint'(mant) + (sgn ? 1024 : 0);
      if (sgn) v = v - 2048;
    end else if (mode == 2'b00) begin
      v = sgn ? -longint'(mant) : longint'(mant);
    end else begin
      s = int'(e) - EXP_BASE;
      if (s < 0) s = 0;
      if (s > MAX_SH) s = MAX_SH;
      v = longint'(mant) * (longint'(1) << s);
      if (sgn) v = -v;
    end
    return v;
  endfunction

  task automatic resolve(input longint total, input bit ovr);
    longint a;
    int e;
    r_ovr  = ovr;
    r_sign = (total < 0);
    a      = (total < 0) ? -total : total;
    r_zero = (a == 0);
    if (a == 0) begin
      r_exp  = 0;
      r_mant = 0;
    end else begin
      e = 0;
      while ((a >> (e + 1)) != 0) e++;
      r_exp = e;
      if (e >= MANT_W - 1) r_mant = int'(a >> (e - (MANT_W - 1)));
      else                 r_mant = int'(a << ((MANT_W - 1) - e));
      r_mant = r_mant & ((1 << MANT_W) - 1);
    end
  endtask

  // Model steps on the active edge with the bench's own view of busy/valid.
  always @(posedge clk) begin
    if (rst) begin
      m_rst  = 1;
      m_acc  = 0;
      m_cnt  = 0;
      m_busy = 0;
      m_vld  = 0;
      m_cd   = 0;
    end else begin
      m_rst = 0;
      if (m_vld) begin
        if (out_ready) begin
          m_vld  = 0;
          m_busy = 0;
        end
      end else if (m_busy) begin
        m_cd--;
        if (m_cd == 0) m_vld = 1;
      end else if (in_valid) begin
        m_acc += model_term(prec_mode, in_mant, in_exp, in_sign);
        if (in_last || m_cnt == MAX_BEATS - 1) begin
          resolve(m_acc, !in_last);
          m_busy = 1;
          m_cd   = 3;
          m_acc  = 0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    cmp("in_ready", 64'(in_ready), 64'(!rst && !m_busy));
    if (m_rst) begin
      cmp("rst.out_valid", 64'(out_valid), 64'd0);
      cmp("rst.out_sign", 64'(out_sign), 64'd0);
      cmp("rst.out_exp", 64'(out_exp), 64'd0);
      cmp("rst.out_mant", 64'(out_mant), 64'd0);
      cmp("rst.out_zero", 64'(out_zero), 64'd0);
      cmp("rst.out_overrun", 64'(out_overrun), 64'd0);
    end else begin
      cmp("out_valid", 64'(out_valid), 64'(m_vld));
      if (m_vld) begin
        cmp("model.sign", 64'(out_sign), 64'(r_sign));
        cmp("model.exp", 64'(out_exp), 64'(r_exp));
        cmp("model.mant", 64'(out_mant), 64'(r_mant));
        cmp("model.zero", 64'(out_zero), 64'(r_zero));
        cmp("model.overrun", 64'(out_overrun), 64'(r_ovr));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Drives one beat for one cycle; called #1 after an active edge.
  task automatic applyStimulus(input logic [1:0] mode, input logic [9:0] mant,
                               input logic [5:0] e, input logic sgn, input logic last);
    in_valid  = 1'b1;
    prec_mode = mode;
    in_mant   = mant;
    in_exp    = e;
    in_sign   = sgn;
    in_last   = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits (bounded) for out_valid and checks the close-to-valid latency.
  task automatic waitValid(input string name);
    int lat;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) break;
    end
    cmp({name, ".latency"}, 64'(lat), 64'd4);
  endtask

  task automatic checkOutput(input string name, input logic sgn, input int e,
                             input int mant, input logic zero, input logic ovr);
    cmp({name, ".out_valid"}, 64'(out_valid), 64'd1);
    cmp({name, ".sign"}, 64'(out_sign), 64'(sgn));
    cmp({name, ".exp"}, 64'(out_exp), 64'(e));
    cmp({name, ".mant"}, 64'(out_mant), 64'(mant));
    cmp({name, ".zero"}, 64'(out_zero), 64'(zero));
    cmp({name, ".overrun"}, 64'(out_overrun), 64'(ovr));
  endtask

  // Lets the handshake edge pass and lands #1 after it, ready for a new block.
  task automatic endBlock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("post_rst.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // INT8 single beat: 5 -> leading one at bit 2
    applyStimulus(2'b00, 10'd5, 6'd0, 1'b0, 1'b1);
    waitValid("int8");
    checkOutput("int8", 1'b0, 2, 'hA0, 1'b0, 1'b0);
    endBlock();

    // FP4: -10 + 4 = -6
    applyStimulus(2'b11, 10'h3F6, 6'd0, 1'b1, 1'b0);
    applyStimulus(2'b11, 10'h004, 6'd0, 1'b0, 1'b1);
    waitValid("fp4");
    checkOutput("fp4", 1'b1, 2, 'hC0, 1'b0, 1'b0);
    endBlock();

    // FP8 shift clamp at both ends
    applyStimulus(2'b01, 10'd1, 6'd14, 1'b0, 1'b1);
    waitValid("fp8_e14");
    checkOutput("fp8_e14", 1'b0, 12, 'h80, 1'b0, 1'b0);
    endBlock();
    applyStimulus(2'b10, 10'd1, 6'd20, 1'b0, 1'b1);
    waitValid("fp8_e20");
    checkOutput("fp8_e20", 1'b0, 12, 'h80, 1'b0, 1'b0);
    endBlock();
    applyStimulus(2'b01, 10'd1, 6'd1, 1'b0, 1'b1);
    waitValid("fp8_e1");
    checkOutput("fp8_e1", 1'b0, 0, 'h80, 1'b0, 1'b0);
    endBlock();

    // Cancellation to exact zero
    applyStimulus(2'b00, 10'd7, 6'd0, 1'b0, 1'b0);
    applyStimulus(2'b00, 10'd7, 6'd0, 1'b1, 1'b1);
    waitValid("cancel");
    checkOutput("cancel", 1'b0, 0, 0, 1'b1, 1'b0);
    endBlock();

    // Overrun: eight full-scale FP8 beats, no in_last
    for (int i = 0; i < MAX_BEATS; i++) begin
      applyStimulus(2'b01, 10'd1023, 6'd14, 1'b0, 1'b0);
    end
    waitValid("overrun");
    checkOutput("overrun", 1'b0, 24, 'hFF, 1'b0, 1'b1);
    endBlock();

    // Backpressure on a mixed-mode block: 3<<3 - 1 = 23
    out_ready = 1'b0;
    applyStimulus(2'b01, 10'd3, 6'd5, 1'b0, 1'b0);
    applyStimulus(2'b00, 10'd1, 6'd0, 1'b1, 1'b1);
    waitValid("bp");
    checkOutput("bp", 1'b0, 4, 'hB8, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold", 1'b0, 4, 'hB8, 1'b0, 1'b0);
      cmp("bp_hold.in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    endBlock();
    @(negedge clk);
    cmp("bp_after.out_valid", 64'(out_valid), 64'd0);
    cmp("bp_after.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Reset during normalization aborts the block
    applyStimulus(2'b01, 10'd1023, 6'd14, 1'b1, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("abort.in_ready", 64'(in_ready), 64'd1);
    cmp("abort.out_valid", 64'(out_valid), 64'd0);
    repeat (6) @(negedge clk);
    cmp("abort_idle.out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Following block must carry no residue
    applyStimulus(2'b00, 10'd3, 6'd0, 1'b0, 1'b1);
    waitValid("residue");
    checkOutput("residue", 1'b0, 1, 'hC0, 1'b0, 1'b0);
    endBlock();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
